// File: rtl/dcache_wt_param.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; misses and stores run a backing-memory handshake.
module dcache_wt_param #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int LINES  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL_REQ  = 3'd1;
  localparam logic [2:0] S_FILL_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ    = 3'd3;
  localparam logic [2:0] S_WR_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic              r_filled;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_rd_hit;
  logic              w_rd_miss;
  logic              w_fill;
  logic              w_wr_accept;
  logic [LINES-1:0]  w_fill_sel;

  assign w_idx       = addr[IDX_W-1:0];
  assign w_tag       = addr[ADDR_W-1:IDX_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd_hit    = (r_state == S_IDLE) && req_valid && !req_we && w_hit;
  assign w_rd_miss   = (r_state == S_IDLE) && req_valid && !req_we && !w_hit;
  assign w_fill      = (r_state == S_FILL_WAIT) && mem_resp_valid;
  assign w_wr_accept = (r_state == S_WR_REQ) && mem_req_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line_sel
      assign w_fill_sel[gi] = w_fill && (w_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we)      w_state_next = S_WR_REQ;
          else if (!w_hit) w_state_next = S_FILL_REQ;
        end
      end
      S_FILL_REQ:  if (mem_req_ready)  w_state_next = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_resp_valid) w_state_next = S_IDLE;
      S_WR_REQ:    if (mem_req_ready)  w_state_next = S_WR_DONE;
      S_WR_DONE:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the current state.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rdata         = '0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          stall = req_valid && (req_we || !w_hit);
          if (w_rd_hit) rdata = r_data[w_idx];
        end
        S_FILL_REQ: begin
          stall         = 1'b1;
          mem_req_valid = 1'b1;
          mem_addr      = addr;
        end
        S_FILL_WAIT: stall = 1'b1;
        S_WR_REQ: begin
          stall         = 1'b1;
          mem_req_valid = 1'b1;
          mem_we        = 1'b1;
          mem_addr      = addr;
          mem_wdata     = wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= r_valid | w_fill_sel;
    end
  end

  // Tag/data storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_fill) begin
        r_tag[w_idx]  <= w_tag;
        r_data[w_idx] <= mem_rdata;
      end else if (w_wr_accept && w_hit) begin
        r_data[w_idx] <= wdata;
      end
    end
  end

  // A hit that immediately follows its own fill is the retirement of the miss, not a new hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_filled   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rd_hit) begin
        if (!r_filled && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        r_filled <= 1'b0;
      end
      if (w_fill) r_filled <= 1'b1;
      if (w_rd_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
